// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: control and result stage for the ALU's 7:1 result mux.
// A request (opcode plus two operands) is accepted in IDLE. The operands and
// the opcode are registered, and the opcode drives the mux select lines. After
// SETTLE cycles the mux output is captured together with the zero and negative
// flags. Opcode 3'b111 has no mux input: it gets an immediate err response and
// leaves the previous result visible.
//
// Optional feature macro: ALU_ACC_EN. When it is defined, an acc_sel input is
// added. acc_sel=1 at accept takes operand A from the last captured result,
// which allows chained operations.
//
// Handshake: start is sampled only in IDLE. done is high in DONE and is held
// until ack is sampled high. ack outside DONE and start outside IDLE have no
// effect, and the operands are not re-latched.

module alu_op_sequencer #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
`ifdef ALU_ACC_EN
    input  logic             acc_sel,
`endif
    input  logic             ack,
    output logic             busy,
    output logic             done,
    output logic [2:0]       sel,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] mux_y,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             neg,
    output logic             err
);

    // The settle counter is 4 bits wide because SETTLE is limited to 1..15.
    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);
    localparam logic [2:0] OP_INVALID = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [3:0]       cnt;
    logic             accept;
    logic             accept_valid;
    logic             accept_invalid;
    logic             capture;
    logic [WIDTH-1:0] a_src;

    // Decode the accept and capture events from the current state and inputs.
    always_comb begin
        accept         = (state == ST_IDLE) && start;
        accept_valid   = accept && (opcode != OP_INVALID);
        accept_invalid = accept && (opcode == OP_INVALID);
        capture        = (state == ST_SETTLE) && (cnt == 4'd1);
    end

    // Select the source of operand A. The accumulator path is optional.
    always_comb begin
`ifdef ALU_ACC_EN
        a_src = acc_sel ? result : a_in;
`else
        a_src = a_in;
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept -> settle -> done -> wait for ack.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept_valid) begin
                    state_next = ST_SETTLE;
                end else if (accept_invalid) begin
                    state_next = ST_DONE;
                end
            end
            ST_SETTLE: begin
                if (capture) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (ack) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Status outputs depend only on the state register.
    always_comb begin
        busy = (state != ST_IDLE);
        done = (state == ST_DONE);
    end

    // Register the select and operands on a valid accept. They stay stable
    // until the next valid accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel  <= 3'b000;
            op_a <= '0;
            op_b <= '0;
        end else if (accept_valid) begin
            sel  <= opcode;
            op_a <= a_src;
            op_b <= b_in;
        end
    end

    // Settle counter: loaded on accept and decremented every edge while settling.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 4'd0;
        end else if (accept_valid) begin
            cnt <= SETTLE_CNT;
        end else if (state == ST_SETTLE) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Capture the mux output and its flags. Nothing else changes them, so an
    // err response leaves the previous result visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
            zero   <= 1'b0;
            neg    <= 1'b0;
        end else if (capture) begin
            result <= mux_y;
            zero   <= (mux_y == '0);
            neg    <= mux_y[WIDTH-1];
        end
    end

    // Error flag: set by an invalid request and cleared by the next valid one.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (accept_invalid) begin
            err <= 1'b1;
        end else if (accept_valid) begin
            err <= 1'b0;
        end
    end

    // Simulation-time sanity check of the settle parameter range.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (SETTLE >= 1 && SETTLE <= 15)
                else $error("alu_op_sequencer: SETTLE=%0d outside 1..15", SETTLE);
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: directed scenarios followed by random
// traffic, all checked against a transaction-level model of the sequencer.
module tb_alu_op_sequencer;

  localparam int W      = 4;
  localparam int SETTLE = 3;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   opcode = 3'b000;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         acc_sel = 1'b0;
  logic         ack = 1'b0;
  logic [W-1:0] mux_y = '0;
  logic         busy, done, zero, neg, err;
  logic [2:0]   sel;
  logic [W-1:0] op_a, op_b, result;

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(W), .SETTLE(SETTLE)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .opcode(opcode),
    .a_in(a_in),
    .b_in(b_in),
`ifdef ALU_ACC_EN
    .acc_sel(acc_sel),
`endif
    .ack(ack),
    .busy(busy),
    .done(done),
    .sel(sel),
    .op_a(op_a),
    .op_b(op_b),
    .mux_y(mux_y),
    .result(result),
    .zero(zero),
    .neg(neg),
    .err(err)
  );

  // ---------------- ALU function units seen through the mux ----------------
  function automatic logic [W-1:0] alu(input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
    case (s)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a << 1;
      3'd3: return a & b;
      3'd4: return a | b;
      3'd5: return a ^ b;
      3'd6: return ~a;
      default: return '0;
    endcase
  endfunction

  // ---------------- check bookkeeping ----------------
  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- transaction-level model ----------------
  // A request is "in flight" from its accept edge until the edge numbered
  // accept + SETTLE, where the mux value is taken; then the response is
  // pending until ack.
  int           edge_no = 0;
  int           cap_at = 0;
  logic         m_live = 1'b0;
  logic         m_inflight = 1'b0;
  logic         m_done = 1'b0;
  logic         m_err = 1'b0;
  logic         m_zero = 1'b0;
  logic         m_neg = 1'b0;
  logic [2:0]   m_sel = '0;
  logic [W-1:0] m_a = '0;
  logic [W-1:0] m_b = '0;
  logic [W-1:0] m_result = '0;
  logic [W-1:0] exp_q[$];

  always @(posedge clk) begin
    edge_no <= edge_no + 1;
    if (rst) begin
      m_live <= 1'b1; m_inflight <= 1'b0; m_done <= 1'b0; m_err <= 1'b0;
      m_zero <= 1'b0; m_neg <= 1'b0; m_sel <= '0; m_a <= '0; m_b <= '0;
      m_result <= '0;
      exp_q.delete();
    end else if (m_inflight) begin
      if (edge_no + 1 == cap_at) begin
        m_result   <= alu(m_sel, m_a, m_b);
        m_zero     <= (alu(m_sel, m_a, m_b) == '0);
        m_neg      <= alu(m_sel, m_a, m_b) >= W'(1 << (W - 1));
        m_inflight <= 1'b0;
        m_done     <= 1'b1;
        exp_q.push_back(alu(m_sel, m_a, m_b));
      end
    end else if (m_done) begin
      if (ack) m_done <= 1'b0;
    end else if (start) begin
      if (opcode == 3'b111) begin
        m_err  <= 1'b1;
        m_done <= 1'b1;
      end else begin
        m_sel <= opcode;
`ifdef ALU_ACC_EN
        m_a <= acc_sel ? m_result : a_in;
`else
        m_a <= a_in;
`endif
        m_b        <= b_in;
        m_err      <= 1'b0;
        m_inflight <= 1'b1;
        cap_at     <= edge_no + 1 + SETTLE;
      end
    end
  end

  // Mux model: it returns the true function only for the edge where a capture
  // is due. On every other cycle it returns the complement, so a capture at
  // the wrong edge picks up a wrong value.
  always @(negedge clk) begin
    if (m_inflight && (edge_no + 1 == cap_at)) mux_y = alu(sel, op_a, op_b);
    else mux_y = ~alu(sel, op_a, op_b);
  end

  // ---------------- compare process ----------------
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (m_live) begin
      chk("busy",   busy,   m_inflight | m_done);
      chk("done",   done,   m_done);
      chk("err",    err,    m_err);
      chk("sel",    sel,    m_sel);
      chk("op_a",   op_a,   m_a);
      chk("op_b",   op_b,   m_b);
      chk("result", result, m_result);
      chk("zero",   zero,   m_zero);
      chk("neg",    neg,    m_neg);
      if (done === 1'b1 && prev_done !== 1'b1 && err === 1'b0) begin
        chk("scoreboard_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("scoreboard_result", result, exp_q.pop_front());
      end
    end
    prev_done <= done;
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic acc);
    @(negedge clk);
    start = 1'b1; opcode = op; a_in = a; b_in = b; acc_sel = acc;
    @(negedge clk);
    start = 1'b0; acc_sel = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < 50) begin
      @(negedge clk);
      cycles++;
    end
    if (done !== 1'b1) chk("done_timeout", done, 1);
  endtask

  task automatic do_ack();
    @(negedge clk);
    start = 1'b0; ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("ack_clears_done", done, 0);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int cyc;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_sel", sel, 0);
    chk("reset_result", result, 0);

    // Basic operation: shift-left of 5 gives 4'hA.
    issue(3'b010, 4'h5, 4'h3, 1'b0);
    chk("basic_sel", sel, 3'b010);
    chk("basic_op_a", op_a, 4'h5);
    chk("basic_op_b", op_b, 4'h3);
    wait_done(cyc);
    chk("basic_latency", cyc, SETTLE);
    chk("basic_result", result, 4'hA);
    chk("basic_zero", zero, 0);
    chk("basic_neg", neg, 1);
    do_ack();

    // Zero result (7+9 wraps to 0). The mux reads 4'hF until the capture edge.
    issue(3'b000, 4'h7, 4'h9, 1'b0);
    chk("lat_busy", busy, 1);
    wait_done(cyc);
    chk("lat_latency", cyc, SETTLE);
    chk("lat_result", result, 4'h0);
    chk("lat_zero", zero, 1);
    chk("lat_neg", neg, 0);
    do_ack();

    // Invalid opcode after a result of 6.
    issue(3'b101, 4'h3, 4'h5, 1'b0);
    wait_done(cyc);
    chk("prior_result", result, 4'h6);
    do_ack();
    issue(3'b111, 4'hF, 4'hF, 1'b0);
    chk("inv_done", done, 1);
    chk("inv_err", err, 1);
    chk("inv_result_kept", result, 4'h6);
    chk("inv_sel_kept", sel, 3'b101);
    do_ack();
    issue(3'b011, 4'hC, 4'hA, 1'b0);
    chk("err_cleared", err, 0);
    wait_done(cyc);
    chk("and_result", result, 4'h8);
    do_ack();

    // Handshake abuse: start and ack during settle, start while done is held.
    issue(3'b100, 4'h1, 4'h2, 1'b0);
    start = 1'b1; a_in = 4'hF; ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0; ack = 1'b0;
    chk("abuse_op_a", op_a, 4'h1);
    wait_done(cyc);
    chk("abuse_result", result, 4'h3);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start = (i % 2 == 0); a_in = 4'hE;
      chk("hold_done", done, 1);
      chk("hold_op_a", op_a, 4'h1);
    end
    do_ack();

    // Reset in the middle of settling: no capture takes place.
    issue(3'b001, 4'h9, 4'h2, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_sel", sel, 0);
    chk("midrst_result", result, 0);
    @(negedge clk);
    chk("midrst_no_capture", done, 0);

    // Accumulator chaining: first 3+4=7, then acc_sel=1.
    issue(3'b000, 4'h3, 4'h4, 1'b0);
    wait_done(cyc);
    chk("acc_seed", result, 4'h7);
    do_ack();
    issue(3'b000, 4'h1, 4'h2, 1'b1);
`ifdef ALU_ACC_EN
    chk("acc_op_a", op_a, 4'h7);
`else
    chk("acc_op_a", op_a, 4'h1);
`endif
    chk("acc_op_b", op_b, 4'h2);
    wait_done(cyc);
    do_ack();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      rst     = ($urandom_range(0, 63) == 0);
      start   = ($urandom_range(0, 2) == 0);
      opcode  = 3'($urandom_range(0, 7));
      a_in    = W'($urandom_range(0, 15));
      b_in    = W'($urandom_range(0, 15));
      ack     = ($urandom_range(0, 3) == 0);
      acc_sel = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0; ack = 1'b1;
    repeat (SETTLE + 4) @(negedge clk);
    ack = 1'b0;
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
